// File: rtl/vdp_sync_gen_pkg.sv
// Shared XGA raster geometry for the VDP sync generator and anything that models screen layout.
// Also holds the registered output bundle type and the sync polarity helper.
package vdp_sync_gen_pkg;

    localparam int XGA_H_VIS  = 1024;
    localparam int XGA_H_FP   = 24;
    localparam int XGA_H_SYNC = 136;
    localparam int XGA_H_BP   = 160;
    localparam int XGA_V_VIS  = 768;
    localparam int XGA_V_FP   = 3;
    localparam int XGA_V_SYNC = 6;
    localparam int XGA_V_BP   = 29;

    localparam bit XGA_HSYNC_POL = 1'b0;
    localparam bit XGA_VSYNC_POL = 1'b0;

    localparam int HCNT_W = 11;
    localparam int VCNT_W = 10;
    localparam int COL_W  = 9;
    localparam int ROW_W  = 10;

    typedef struct packed {
        logic             hsync;
        logic             vsync;
        logic             active;
        logic             line_start;
        logic             frame_start;
        logic             vblank_start;
        logic [COL_W-1:0] col;
        logic [ROW_W-1:0] row;
    } sync_out_t;

    // Drive level of a sync pin given whether the pulse is asserted and its polarity.
    function automatic logic sync_level(input logic asserted, input logic pol);
        return pol ? asserted : ~asserted;
    endfunction

endpackage

// File: rtl/vdp_sync_axis.sv
// One raster axis: wrapping counter with carry-in enable, wrap-out, and visible/sync decode.
// Decode outputs are combinational from the current count; the top registers them.
module vdp_sync_axis
    import vdp_sync_gen_pkg::*;
#(
    parameter int VIS  = 1024,
    parameter int FP   = 24,
    parameter int SYNC = 136,
    parameter int BP   = 160,
    parameter bit POL  = 1'b0,
    parameter int W    = 11
) (
    input  logic         pxclk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         visible,
    output logic         sync,
    output logic         first
);

    localparam int            TOTAL = VIS + FP + SYNC + BP;
    localparam logic [W-1:0]  LAST  = W'(TOTAL - 1);

    logic in_sync;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge pxclk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

    always_comb begin
        wrap    = en && (count == LAST);
        first   = (count == '0);
        visible = int'(count) < VIS;
        in_sync = (int'(count) >= VIS + FP) && (int'(count) < VIS + FP + SYNC);
        sync    = sync_level(in_sync, POL);
    end

endmodule

// File: rtl/vdp_sync_gen.sv
// Raster timing generator: H/V axes, column/row slicing, line/frame/vblank strobes,
// all outputs registered together so they describe the same pixel one clock later.
module vdp_sync_gen
    import vdp_sync_gen_pkg::*;
#(
    parameter int H_VIS     = XGA_H_VIS,
    parameter int H_FP      = XGA_H_FP,
    parameter int H_SYNC    = XGA_H_SYNC,
    parameter int H_BP      = XGA_H_BP,
    parameter int V_VIS     = XGA_V_VIS,
    parameter int V_FP      = XGA_V_FP,
    parameter int V_SYNC    = XGA_V_SYNC,
    parameter int V_BP      = XGA_V_BP,
    parameter bit HSYNC_POL = XGA_HSYNC_POL,
    parameter bit VSYNC_POL = XGA_VSYNC_POL,
    parameter int COL_SHIFT = 1
) (
    input  logic             pxclk,
    input  logic             reset,
    output logic             hsync,
    output logic             vsync,
    output logic             active,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             line_start,
    output logic             frame_start,
    output logic             vblank_start
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > (1 << HCNT_W)) begin : g_h_range
        $error("vdp_sync_gen: H_TOTAL %0d exceeds 11-bit hcount", H_TOTAL);
    end
    if (V_TOTAL > (1 << VCNT_W)) begin : g_v_range
        $error("vdp_sync_gen: V_TOTAL %0d exceeds 10-bit vcount", V_TOTAL);
    end

    localparam sync_out_t OUT_RST = '{
        hsync: ~HSYNC_POL, vsync: ~VSYNC_POL, active: 1'b0, line_start: 1'b0,
        frame_start: 1'b0, vblank_start: 1'b0, col: '0, row: '0
    };

    logic [1:0]        rst_sync;
    logic              rst_n;
    logic [HCNT_W-1:0] h_count;
    logic [VCNT_W-1:0] v_count;
    logic              h_wrap, h_vis, h_sync_lvl, h_first;
    logic              v_wrap_unused, v_vis, v_sync_lvl, v_first;
    sync_out_t         out_d, out_q;

    // NOTE: reset asserts asynchronously but releases through two flops, so all state leaves reset on one edge.
    always_ff @(posedge pxclk or negedge reset) begin
        if (!reset) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end
    assign rst_n = rst_sync[1];

    vdp_sync_axis #(
        .VIS(H_VIS), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HSYNC_POL), .W(HCNT_W)
    ) u_h (
        .pxclk(pxclk), .rst_n(rst_n), .en(1'b1), .count(h_count), .wrap(h_wrap),
        .visible(h_vis), .sync(h_sync_lvl), .first(h_first)
    );

    vdp_sync_axis #(
        .VIS(V_VIS), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VSYNC_POL), .W(VCNT_W)
    ) u_v (
        .pxclk(pxclk), .rst_n(rst_n), .en(h_wrap), .count(v_count), .wrap(v_wrap_unused),
        .visible(v_vis), .sync(v_sync_lvl), .first(v_first)
    );

    // col/row follow the counters even in blanking; consumers qualify with active.
    always_comb begin
        out_d              = OUT_RST;
        out_d.hsync        = h_sync_lvl;
        out_d.vsync        = v_sync_lvl;
        out_d.active       = h_vis && v_vis;
        out_d.line_start   = h_first;
        out_d.frame_start  = h_first && v_first;
        out_d.vblank_start = h_first && (int'(v_count) == V_VIS);
        out_d.col          = COL_W'(h_count >> COL_SHIFT);
        out_d.row          = ROW_W'(v_count);
    end

    always_ff @(posedge pxclk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= OUT_RST;
        end else begin
            out_q <= out_d;
        end
    end

    assign hsync        = out_q.hsync;
    assign vsync        = out_q.vsync;
    assign active       = out_q.active;
    assign col          = out_q.col;
    assign row          = out_q.row;
    assign line_start   = out_q.line_start;
    assign frame_start  = out_q.frame_start;
    assign vblank_start = out_q.vblank_start;

endmodule

// File: tb/tb_vdp_sync_gen.sv
// Bench for vdp_sync_gen: one XGA instance plus two reduced-geometry instances (both polarities)
// checked every cycle against an arithmetic raster model, with random mid-frame resets.
module tb_vdp_sync_gen;

    typedef struct packed {
        int hv; int hfp; int hs; int hbp;
        int vv; int vfp; int vs; int vbp;
        bit hpol; bit vpol;
    } geom_t;

    localparam geom_t G_XGA = '{1024, 24, 136, 160, 768, 3, 6, 29, 1'b0, 1'b0};
    localparam geom_t G_SM0 = '{16, 2, 4, 3, 8, 1, 2, 2, 1'b0, 1'b0};
    localparam geom_t G_SM1 = '{16, 2, 4, 3, 8, 1, 2, 2, 1'b1, 1'b1};

    logic pxclk = 1'b0;
    logic reset = 1'b0;
    int   edges = 0;
    int   vectors = 0;
    int   miscompares = 0;

    logic       x_hs, x_vs, x_act, x_ls, x_fs, x_vb;
    logic [8:0] x_col;
    logic [9:0] x_row;
    logic       a_hs, a_vs, a_act, a_ls, a_fs, a_vb;
    logic [8:0] a_col;
    logic [9:0] a_row;
    logic       b_hs, b_vs, b_act, b_ls, b_fs, b_vb;
    logic [8:0] b_col;
    logic [9:0] b_row;

    always #5 pxclk = ~pxclk;

    // Posedges seen with reset released; outputs show pixel (edges-3) from the third edge on.
    always @(posedge pxclk) edges <= reset ? edges + 1 : 0;

    vdp_sync_gen u_xga (
        .pxclk(pxclk), .reset(reset), .hsync(x_hs), .vsync(x_vs), .active(x_act),
        .col(x_col), .row(x_row), .line_start(x_ls), .frame_start(x_fs), .vblank_start(x_vb)
    );

    vdp_sync_gen #(
        .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(3), .V_VIS(8), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .COL_SHIFT(1)
    ) u_sm0 (
        .pxclk(pxclk), .reset(reset), .hsync(a_hs), .vsync(a_vs), .active(a_act),
        .col(a_col), .row(a_row), .line_start(a_ls), .frame_start(a_fs), .vblank_start(a_vb)
    );

    vdp_sync_gen #(
        .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(3), .V_VIS(8), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .COL_SHIFT(1)
    ) u_sm1 (
        .pxclk(pxclk), .reset(reset), .hsync(b_hs), .vsync(b_vs), .active(b_act),
        .col(b_col), .row(b_row), .line_start(b_ls), .frame_start(b_fs), .vblank_start(b_vb)
    );

    // Expected {hsync,vsync,active,line_start,frame_start,vblank_start,col,row}.
    function automatic logic [24:0] model(input geom_t g, input bit in_reset, input int k);
        int ht, vt, p, h, v;
        logic hs_a, vs_a;
        if (in_reset || k < 3) return {~g.hpol, ~g.vpol, 4'b0000, 9'd0, 10'd0};
        ht   = g.hv + g.hfp + g.hs + g.hbp;
        vt   = g.vv + g.vfp + g.vs + g.vbp;
        p    = (k - 3) % (ht * vt);
        h    = p % ht;
        v    = p / ht;
        hs_a = (h >= g.hv + g.hfp) && (h < g.hv + g.hfp + g.hs);
        vs_a = (v >= g.vv + g.vfp) && (v < g.vv + g.vfp + g.vs);
        return {hs_a ? g.hpol : ~g.hpol, vs_a ? g.vpol : ~g.vpol,
                (h < g.hv) && (v < g.vv), h == 0, p == 0, (h == 0) && (v == g.vv),
                9'(h / 2), 10'(v)};
    endfunction

    task automatic check(input string tag, input logic [24:0] obs, input logic [24:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s k=%0d observed=%h expected=%h", tag, edges, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("xga", {x_hs, x_vs, x_act, x_ls, x_fs, x_vb, x_col, x_row}, model(G_XGA, !reset, edges));
        check("sm0", {a_hs, a_vs, a_act, a_ls, a_fs, a_vb, a_col, a_row}, model(G_SM0, !reset, edges));
        check("sm1", {b_hs, b_vs, b_act, b_ls, b_fs, b_vb, b_col, b_row}, model(G_SM1, !reset, edges));
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge pxclk);
            check_all();
        end
    endtask

    initial begin
        int   last_ls = -1, x_act0 = 0, x_hslow0 = 0, x_hs_off = -1, x_last_col = -1;
        int   fs_seen = 0, fs_k0 = 0, sm_period = -1, sm_act = 0, a_vslow = 0, b_vshigh = 0;
        int   vs_row = -1, vs_col = -1, vb_cnt = 0, vb_row = -1, vb_col = -1;
        logic prev_x_hs = 1'b1, prev_a_vs = 1'b1;

        run_cycles(10);
        reset = 1'b1;

        for (int i = 0; i < 4040; i++) begin
            @(negedge pxclk);
            check_all();
            if (x_ls) begin
                if (last_ls >= 0) check_int("xga_line_period", edges - last_ls, 1344);
                last_ls = edges;
            end
            if (edges >= 3 && x_row == 10'd0) begin
                if (x_act) begin
                    x_act0++;
                    x_last_col = int'(x_col);
                end
                if (!x_hs) begin
                    x_hslow0++;
                    if (prev_x_hs) x_hs_off = edges - last_ls;
                end
            end
            prev_x_hs = x_hs;
            if (a_fs) begin
                check_int("sm_fs_rowcol", int'({a_row, a_col}), 0);
                if (fs_seen == 1) sm_period = edges - fs_k0;
                if (fs_seen == 0) fs_k0 = edges;
                fs_seen++;
            end
            if (fs_seen == 1) begin
                if (a_act) sm_act++;
                if (!a_vs) a_vslow++;
                if (b_vs) b_vshigh++;
                if (!a_vs && prev_a_vs) begin
                    vs_row = int'(a_row);
                    vs_col = int'(a_col);
                end
                if (a_vb) begin
                    vb_cnt++;
                    vb_row = int'(a_row);
                    vb_col = int'(a_col);
                end
            end
            prev_a_vs = a_vs;
        end

        check_int("xga_row0_active", x_act0, 1024);
        check_int("xga_row0_last_col", x_last_col, 511);
        check_int("xga_row0_hsync_low", x_hslow0, 136);
        check_int("xga_hsync_start_h", x_hs_off, 1048);
        check_int("sm_frame_period", sm_period, 325);
        check_int("sm_frame_active", sm_act, 128);
        check_int("sm0_vsync_low", a_vslow, 50);
        check_int("sm1_vsync_high", b_vshigh, 50);
        check_int("sm_vsync_start_row", vs_row, 9);
        check_int("sm_vsync_start_col", vs_col, 0);
        check_int("sm_vblank_count", vb_cnt, 1);
        check_int("sm_vblank_row", vb_row, 8);
        check_int("sm_vblank_col", vb_col, 0);

        // Random mid-frame resets, asserted between clock edges.
        for (int r = 0; r < 6; r++) begin
            run_cycles(int'($urandom_range(900, 40)));
            #2 reset = 1'b0;
            #1 check_all();
            run_cycles(int'($urandom_range(4, 1)));
            reset = 1'b1;
        end
        run_cycles(400);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
